// File: rtl/vm_pkg.sv
// Shared constants and types for the vending machine credit/return path.
// This file holds the coin table, the price table, the controller state enum and a table sanity check.
package vm_pkg;

  localparam int NUM_COINS = 3;
  localparam int NUM_ITEMS = 4;

  // Index 0 is the smallest denomination; the greedy return relies on ascending order.
  localparam int COIN_VALUE [NUM_COINS] = '{100, 500, 1000};
  localparam int ITEM_PRICE [NUM_ITEMS] = '{400, 500, 1000, 2000};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    RETURN = 2'd2
  } vm_state_e;

  // Every value must be a multiple of the smallest coin, or change return could strand credit.
  function automatic bit tables_ok();
    bit ok;
    ok = (COIN_VALUE[0] > 0);
    for (int i = 0; i < NUM_COINS; i++) begin
      if ((COIN_VALUE[i] % COIN_VALUE[0]) != 0) ok = 1'b0;
    end
    for (int i = 1; i < NUM_COINS; i++) begin
      if (COIN_VALUE[i] <= COIN_VALUE[i-1]) ok = 1'b0;
    end
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if ((ITEM_PRICE[i] % COIN_VALUE[0]) != 0 || ITEM_PRICE[i] <= 0) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/vm_wait_timer.sv
// Reloadable inactivity down-counter: load wins, otherwise counts down to zero while enabled.
module vm_wait_timer #(
  parameter int WAIT_CYCLES = 100,
  parameter int CNT_W       = $clog2(WAIT_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic             i_enable,
  output logic [CNT_W-1:0] o_count,
  output logic             o_zero
);

  logic [CNT_W-1:0] count_d, count_q;

  assign o_zero  = (count_q == '0);
  assign o_count = count_q;

  // NOTE: every variable driven from always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    if (i_load) begin
      count_d = CNT_W'(WAIT_CYCLES);
    end else if (i_enable && !o_zero) begin
      count_d = count_q - 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vm_credit_return_ctrl.sv
// Credit accumulation, purchase granting, inactivity timeout and greedy change return.
module vm_credit_return_ctrl
  import vm_pkg::*;
#(
  parameter int WAIT_CYCLES = 100,
  parameter int CREDIT_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_COINS-1:0] i_input_coin,
  input  logic [NUM_ITEMS-1:0] i_select_item,
  input  logic                 i_trigger_return,
  output logic [NUM_ITEMS-1:0] o_available_item,
  output logic [NUM_ITEMS-1:0] o_output_item,
  output logic [NUM_COINS-1:0] o_return_coin,
  output logic                 o_reject,
  output logic [CREDIT_W-1:0]  o_credit,
  output logic [31:0]          o_wait_time
);

  localparam int SUM_W   = CREDIT_W + 1;
  localparam int TIMER_W = $clog2(WAIT_CYCLES + 1);
  localparam logic [SUM_W-1:0] CREDIT_MAX = {1'b0, {CREDIT_W{1'b1}}};

  if (!tables_ok()) begin : g_bad_tables
    $fatal(1, "vm_pkg coin/price tables are inconsistent");
  end

  vm_state_e              state_d, state_q;
  logic [CREDIT_W-1:0]    credit_d, credit_q;
  logic [NUM_ITEMS-1:0]   output_item_d, output_item_q;
  logic [NUM_COINS-1:0]   return_coin_d, return_coin_q;
  logic                   reject_d, reject_q;

  logic [SUM_W-1:0]       deposit, credit_sum, sel_price;
  logic [CREDIT_W-1:0]    credit_dep, ret_value;
  logic [NUM_ITEMS-1:0]   sel_onehot;
  logic [NUM_COINS-1:0]   ret_onehot;
  logic                   coin_any, deposit_ok;
  logic                   timer_load, timer_enable, timer_zero, timer_expire;
  logic [TIMER_W-1:0]     timer_count;

  vm_wait_timer #(
    .WAIT_CYCLES (WAIT_CYCLES),
    .CNT_W       (TIMER_W)
  ) u_wait_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_load   (timer_load),
    .i_enable (timer_enable),
    .o_count  (timer_count),
    .o_zero   (timer_zero)
  );

  // Deposit value, overflow test and lowest-index item selection.
  always_comb begin
    deposit = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (i_input_coin[i]) deposit = deposit + SUM_W'(COIN_VALUE[i]);
    end
    coin_any   = |i_input_coin;
    credit_sum = {1'b0, credit_q} + deposit;
    deposit_ok = coin_any && (credit_sum <= CREDIT_MAX);
    credit_dep = deposit_ok ? credit_sum[CREDIT_W-1:0] : credit_q;

    sel_onehot = i_select_item & (~i_select_item + 1'b1);
    sel_price  = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (sel_onehot[i]) sel_price = SUM_W'(ITEM_PRICE[i]);
    end
  end

  // Greedy change: the last fitting coin in ascending order is the largest.
  // If nothing fits, ret_value equals the credit so the drain still ends at zero.
  always_comb begin
    ret_onehot = '0;
    ret_value  = credit_q;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (SUM_W'(COIN_VALUE[i]) <= {1'b0, credit_q}) begin
        ret_onehot    = '0;
        ret_onehot[i] = 1'b1;
        ret_value     = CREDIT_W'(COIN_VALUE[i]);
      end
    end
  end

  assign timer_load   = (state_q != RETURN) && (deposit_ok || (|i_select_item));
  assign timer_enable = (state_q == HOLD);
  // Expire on the cycle the counter would step from 1 to 0.
  assign timer_expire = timer_enable && !timer_load &&
                        (timer_zero || timer_count == TIMER_W'(1));

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    output_item_d = '0;
    return_coin_d = '0;
    reject_d      = 1'b0;
    case (state_q)
      IDLE, HOLD: begin
        reject_d = coin_any && !deposit_ok;
        credit_d = credit_dep;
        if ((state_q == HOLD || deposit_ok) && (|sel_onehot) &&
            ({1'b0, credit_dep} >= sel_price)) begin
          output_item_d = sel_onehot;
          credit_d      = credit_dep - sel_price[CREDIT_W-1:0];
        end
        if (credit_d == '0) begin
          state_d = IDLE;
        end else if (i_trigger_return || timer_expire) begin
          state_d = RETURN;
        end else begin
          state_d = HOLD;
        end
      end
      RETURN: begin
        reject_d      = coin_any;
        return_coin_d = ret_onehot;
        credit_d      = credit_q - ret_value;
        if (credit_d == '0) state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        credit_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      credit_q      <= '0;
      output_item_q <= '0;
      return_coin_q <= '0;
      reject_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      output_item_q <= output_item_d;
      return_coin_q <= return_coin_d;
      reject_q      <= reject_d;
    end
  end

  always_comb begin
    o_available_item = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      o_available_item[i] = (state_q != RETURN) &&
                            ({1'b0, credit_q} >= SUM_W'(ITEM_PRICE[i]));
    end
  end

  assign o_output_item = output_item_q;
  assign o_return_coin = return_coin_q;
  assign o_reject      = reject_q;
  assign o_credit      = credit_q;
  assign o_wait_time   = (state_q == HOLD) ? 32'(timer_count) : 32'd0;

endmodule
